// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding and default fetch vectors.
package core_pkg;

    // Default datapath width for address and instruction words.
    localparam int XLEN = 32;

    // Default first fetch address after reset and exception redirect address.
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEFAULT   = 32'h0000_0080;

    // Fetch controller states.
    //   ST_BOOT  : single settling cycle after reset, no request
    //   ST_FETCH : may issue a new request at pc
    //   ST_WAIT  : request outstanding, pc frozen until ack
    //   ST_HALT  : fetching stopped, only an exception restarts it
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction memory bus between the fetch controller and instruction memory.
//
// Handshake: imem_req_o is a level. While it is high, pc_o is stable and the
// request stays pending until a cycle in which imem_ack_i is also high; in that
// cycle imem_rdata_i carries the word for pc_o and the transfer is complete.
// A request raised in FETCH that meets a redirect in the same cycle without
// an ack is withdrawn; once a request has survived a cycle (WAIT) it is only
// ended by an ack or by reset.
interface fetch_controller_if #(
    parameter int WIDTH = 32
) ();
    logic             imem_req_o;
    logic [WIDTH-1:0] pc_o;
    logic             imem_ack_i;
    logic [WIDTH-1:0] imem_rdata_i;

    // Controller side.
    modport master (
        output imem_req_o,
        output pc_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    // Memory side.
    modport slave (
        input  imem_req_o,
        input  pc_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched word while the IF/ID stage is stalled.
// Control priority: clear > load > release_en.
module fetch_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             release_en,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Entry valid bit and captured word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (release_en) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, sequences instruction memory
// requests, applies redirects (exception > branch > jump), halts, and feeds
// the IF/ID stage directly or from a one-entry skid buffer under stall.
module fetch_controller
    import core_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(RESET_VEC_DEFAULT),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(EXC_VEC_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             exc_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             halt_i,
    fetch_controller_if.master imem,
    output logic             if_valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             flush_if_o,
    output fetch_state_e     state_o
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] drop_tgt_q, drop_tgt_d;
    logic             halt_pend_q, halt_pend_d;

    logic             redir_any;
    logic [WIDTH-1:0] redir_tgt;

    logic             req;
    logic             deliver;
    logic             flush;
    logic             buf_load;
    logic             buf_clear;
    logic             buf_release;
    logic             buf_valid;
    logic [WIDTH-1:0] buf_data;

    assign redir_any = exc_i | branch_i | jump_i;

    // Redirect target by priority: exception, then branch, then jump.
    always_comb begin
        redir_tgt = jump_target_i;
        if (exc_i) begin
            redir_tgt = EXC_VEC;
        end else if (branch_i) begin
            redir_tgt = branch_target_i;
        end
    end

    // Next-state, PC update and per-cycle control outputs.
    // req never depends on imem_ack_i, so there is no ack-to-request path.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        drop_tgt_d  = drop_tgt_q;
        halt_pend_d = halt_pend_q;
        req         = 1'b0;
        deliver     = 1'b0;
        flush       = 1'b0;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                // Redirects and stray acks are ignored while booting.
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                req = !stall_i && !buf_valid && !halt_i;
                if (redir_any) begin
                    // Redirect wins over stall and halt; a same-cycle ack is dropped.
                    flush     = 1'b1;
                    buf_clear = 1'b1;
                    pc_d      = redir_tgt;
                end else if (halt_i) begin
                    state_d = ST_HALT;
                end else if (req) begin
                    if (imem.imem_ack_i) begin
                        pc_d    = pc_q + WIDTH'(4);
                        deliver = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                req = 1'b1;
                if (halt_i) begin
                    halt_pend_d = 1'b1;
                end
                if (redir_any) begin
                    flush     = 1'b1;
                    buf_clear = 1'b1;
                end
                if (imem.imem_ack_i) begin
                    state_d     = (halt_i || halt_pend_q) ? ST_HALT : ST_FETCH;
                    halt_pend_d = 1'b0;
                    drop_d      = 1'b0;
                    if (redir_any) begin
                        pc_d = redir_tgt;
                    end else if (drop_q) begin
                        pc_d = drop_tgt_q;
                    end else begin
                        pc_d = pc_q + WIDTH'(4);
                        if (stall_i) begin
                            buf_load = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end else if (redir_any) begin
                    // Keep the request alive at the old pc; remember where to go.
                    drop_d     = 1'b1;
                    drop_tgt_d = redir_tgt;
                end
            end

            ST_HALT: begin
                if (exc_i) begin
                    flush     = 1'b1;
                    buf_clear = 1'b1;
                    pc_d      = EXC_VEC;
                    state_d   = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, PC, pending-drop and pending-halt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_VEC;
            drop_q      <= 1'b0;
            drop_tgt_q  <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            drop_tgt_q  <= drop_tgt_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // The buffered word leaves on the first unstalled cycle.
    assign buf_release = buf_valid && !stall_i;

    fetch_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .clear      (buf_clear),
        .release_en (buf_release),
        .data_i     (imem.imem_rdata_i),
        .valid_o    (buf_valid),
        .data_o     (buf_data)
    );

    // IF/ID output: buffered word first, else the live ack data.
    always_comb begin
        if_valid_o = 1'b0;
        instr_o    = '0;
        if (buf_valid && !buf_clear) begin
            if_valid_o = 1'b1;
            instr_o    = buf_data;
        end else if (deliver) begin
            if_valid_o = 1'b1;
            instr_o    = imem.imem_rdata_i;
        end
    end

    assign imem.imem_req_o = req;
    assign imem.pc_o       = pc_q;
    assign pc_plus4_o      = pc_q + WIDTH'(4);
    assign flush_if_o      = flush;
    assign state_o         = state_q;

endmodule
